// File: rtl/block_to_raster.sv
// rtl/block_to_raster.sv - 8x8 block stream to raster line reorder
// Two 8-line strip banks ping-pong: one fills in block order while the other drains in raster order.
module block_to_raster #(
  parameter int    WIDTH     = 1280,
  parameter int    HEIGHT    = 720,
  parameter int    DATA_W    = 8,
  parameter string COL_ORDER = "NATURAL"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_sof,
  output logic              out_eof
);

  localparam int  MCUS   = WIDTH / 8;
  localparam int  MW     = (MCUS > 1) ? $clog2(MCUS) : 1;
  localparam int  XW     = MW + 3;
  localparam int  AW     = XW + 3;
  localparam int  DEPTH  = 1 << AW;
  localparam int  STRIPS = HEIGHT / 8;
  localparam int  SW     = (STRIPS > 1) ? $clog2(STRIPS) : 1;
  localparam int  EW     = DATA_W + 4;
  localparam bit  PAIRED = (COL_ORDER == "PAIRED");

  typedef enum logic {S_IDLE, S_READ} state_t;

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  logic [1:0]    full;
  logic          wr_sel, rd_sel;
  logic [2:0]    col, row;
  logic [MW-1:0] mcu;
  logic [2:0]    phys_col;
  logic          wr_en, last_wr;
  logic [AW-1:0] wr_addr, rd_addr;

  state_t        state, state_nx;
  logic [XW-1:0] x;
  logic [2:0]    line;
  logic [SW-1:0] strip;
  logic          rd_en, rd_last, room;
  logic          inflight;
  logic [3:0]    tag, tag_q;
  logic [DATA_W-1:0] rd_data;

  logic [EW-1:0] fifo [2];
  logic          wp, rp;
  logic [1:0]    occ;
  logic          push, pop;
  logic [2:0]    credit;
  logic [EW-1:0] head;
  logic [1:0]    set_mask, clr_mask;

  // Paired order presents columns 0,7,1,6,2,5,3,4: even beats count up, odd beats count down.
  assign phys_col = !PAIRED ? col : (col[0] ? (3'd7 - {1'b0, col[2:1]}) : {1'b0, col[2:1]});

  assign in_ready = !full[wr_sel];
  assign wr_en    = in_valid && in_ready;
  assign last_wr  = (col == 3'd7) && (row == 3'd7) && (mcu == MW'(MCUS - 1));
  assign wr_addr  = {row, mcu, phys_col};
  assign rd_addr  = {line, x};

  always_ff @(posedge clk) begin
    if (wr_en && !wr_sel) bank0[wr_addr] <= in_data;
    if (wr_en && wr_sel)  bank1[wr_addr] <= in_data;
    if (rd_en)            rd_data <= rd_sel ? bank1[rd_addr] : bank0[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      mcu    <= '0;
      wr_sel <= 1'b0;
    end else if (wr_en) begin
      col <= col + 3'd1;
      if (col == 3'd7) begin
        row <= row + 3'd1;
        if (row == 3'd7) mcu <= (mcu == MW'(MCUS - 1)) ? '0 : mcu + 1'b1;
      end
      if (last_wr) wr_sel <= ~wr_sel;
    end
  end

  assign set_mask = {wr_en && last_wr && wr_sel, wr_en && last_wr && !wr_sel};
  assign clr_mask = {rd_last && rd_sel, rd_last && !rd_sel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 2'b00;
      rd_sel <= 1'b0;
    end else begin
      full <= (full | set_mask) & ~clr_mask;
      if (rd_last) rd_sel <= ~rd_sel;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) (set_mask & clr_mask) == 2'b00);

  // A pop this cycle frees a slot, so issue may continue at one pixel per cycle.
  assign pop    = out_valid && out_ready;
  assign push   = inflight;
  assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign room   = credit < 3'd2;

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    rd_last  = 1'b0;
    case (state)
      S_IDLE: if (full[rd_sel]) state_nx = S_READ;
      S_READ: if (room) begin
        rd_en = 1'b1;
        if ((x == XW'(WIDTH - 1)) && (line == 3'd7)) begin
          rd_last  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign tag = {(x == '0) && (line == 3'd0) && (strip == '0),
                (x == XW'(WIDTH - 1)) && (line == 3'd7) && (strip == SW'(STRIPS - 1)),
                (x == '0),
                (x == XW'(WIDTH - 1))};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      x        <= '0;
      line     <= '0;
      strip    <= '0;
      inflight <= 1'b0;
      tag_q    <= '0;
    end else begin
      state    <= state_nx;
      inflight <= rd_en;
      if (rd_en) begin
        tag_q <= tag;
        if (x == XW'(WIDTH - 1)) begin
          x    <= '0;
          line <= line + 3'd1;
          if (line == 3'd7) strip <= (strip == SW'(STRIPS - 1)) ? '0 : strip + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (push) begin
        fifo[wp] <= {tag_q, rd_data};
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head      = fifo[rp];
  assign out_valid = (occ != 2'd0);
  assign out_data  = head[DATA_W-1:0];
  assign out_eol   = out_valid && head[DATA_W];
  assign out_sol   = out_valid && head[DATA_W+1];
  assign out_eof   = out_valid && head[DATA_W+2];
  assign out_sof   = out_valid && head[DATA_W+3];

endmodule

// File: tb/tb_block_to_raster.sv
// tb/tb_block_to_raster.sv - randomized bench for block_to_raster
// Natural and paired instances run in lockstep against a raster image model.
module tb_block_to_raster;

  localparam int W = 16;
  localparam int H = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] din_n = '0, din_p = '0;
  logic rdy_n, rdy_p, ov_n, ov_p;
  logic [7:0] od_n, od_p;
  logic sol_n, eol_n, sof_n, eof_n, sol_p, eol_p, sof_p, eof_p;
  logic [11:0] word_n, word_p;

  always #5 clk = ~clk;

  block_to_raster #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .COL_ORDER("NATURAL")) u_nat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_n), .in_data(din_n),
    .out_valid(ov_n), .out_ready(out_ready), .out_data(od_n),
    .out_sol(sol_n), .out_eol(eol_n), .out_sof(sof_n), .out_eof(eof_n));

  block_to_raster #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .COL_ORDER("PAIRED")) u_pair (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_p), .in_data(din_p),
    .out_valid(ov_p), .out_ready(out_ready), .out_data(od_p),
    .out_sol(sol_p), .out_eol(eol_p), .out_sof(sof_p), .out_eof(eof_p));

  assign word_n = {sof_n, eof_n, sol_n, eol_n, od_n};
  assign word_p = {sof_p, eof_p, sol_p, eol_p, od_p};

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  logic [11:0] exp_q[$];
  logic [7:0] img [H][W];
  int pord [8] = '{0, 7, 1, 6, 2, 5, 3, 4};
  logic [11:0] held;
  bit held_v = 0;
  bit feed_done;

  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst_n) begin
      held_v = 0;
    end else begin
      if (held_v) begin
        checks++;
        assert (ov_n === 1'b1 && word_n === held) else begin
          errors++; $error("FAIL stall_hold observed=%h valid=%b expected=%h", word_n, ov_n, held);
        end
      end
      held_v = 0;
      if (ov_n === 1'b1 && out_ready) begin
        pop_cnt++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++; $error("FAIL extra_out observed=%h expected=none", word_n);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (word_n === e) else begin
            errors++; $error("FAIL out_nat observed=%h expected=%h", word_n, e);
          end
          checks++;
          assert (ov_p === 1'b1 && word_p === e) else begin
            errors++; $error("FAIL out_pair observed=%h valid=%b expected=%h", word_p, ov_p, e);
          end
        end
      end else if (ov_n === 1'b1) begin
        held   = word_n;
        held_v = 1;
      end
    end
  end

  task automatic gen_frame(input bit pattern);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img[y][x] = pattern ? {y[3:0], x[3:0]} : 8'($urandom);
        exp_q.push_back({(x == 0 && y == 0), (x == W-1 && y == H-1), (x == 0), (x == W-1), img[y][x]});
      end
  endtask

  task automatic feed(input int first, input int nbeats, input int vpct);
    int k, guard, r, m, row, c, y;
    bit hs;
    k = first;
    guard = 0;
    while (k < first + nbeats && guard < 20000) begin
      r   = k % 128;
      m   = r / 64;
      row = (r / 8) % 8;
      c   = r % 8;
      y   = (k / 128) * 8 + row;
      in_valid = (int'($urandom_range(99)) < vpct);
      din_n = img[y][m*8 + c];
      din_p = img[y][m*8 + pord[c]];
      hs = in_valid && (rdy_n === 1'b1);
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    assert (k == first + nbeats) else begin
      errors++; $error("FAIL feed_timeout observed=%0d expected=%0d", k, first + nbeats);
    end
  endtask

  task automatic drain();
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL drain_left observed=%0d expected=0", exp_q.size());
    end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    assert (ov_n === 1'b0) else begin
      errors++; $error("FAIL no_dup observed=%b expected=0", ov_n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    time t0;
    int guard;

    // reset state
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    assert (ov_n === 1'b0 && word_n[11:8] === 4'b0000) else begin
      errors++; $error("FAIL reset_out observed=%b/%b expected=0/0000", ov_n, word_n[11:8]);
    end
    checks++;
    assert (rdy_n === 1'b1) else begin
      errors++; $error("FAIL reset_ready observed=%b expected=1", rdy_n);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pattern frame with latency check after the first strip
    gen_frame(1);
    out_ready = 1'b1;
    feed(0, 128, 100);
    for (int i = 0; i < 3; i++) begin
      checks++;
      assert (ov_n === 1'b0) else begin
        errors++; $error("FAIL latency_early edge=%0d observed=%b expected=0", i, ov_n);
      end
      @(posedge clk); #1;
    end
    checks++;
    assert (ov_n === 1'b1) else begin
      errors++; $error("FAIL latency_rise observed=%b expected=1", ov_n);
    end
    feed(128, 128, 100);
    drain();

    // four random frames with random backpressure
    feed_done = 0;
    fork
      begin
        for (int f = 0; f < 4; f++) begin
          gen_frame(0);
          feed(0, 256, 70);
        end
        feed_done = 1;
      end
      begin
        while (!feed_done) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(1);
        end
      end
    join
    drain();

    // both banks full
    do_reset();
    gen_frame(0);
    t0 = $time;
    feed(0, 256, 100);
    checks++;
    assert (($time - t0) == 2560) else begin
      errors++; $error("FAIL in_rate observed=%0t expected=2560", $time - t0);
    end
    checks++;
    assert (rdy_n === 1'b0) else begin
      errors++; $error("FAIL full_ready observed=%b expected=0", rdy_n);
    end
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    assert (rdy_n === 1'b0 && ov_n === 1'b1) else begin
      errors++; $error("FAIL full_hold observed=%b/%b expected=0/1", rdy_n, ov_n);
    end
    pop_cnt = 0;
    out_ready = 1'b1;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (rdy_n !== 1'b1 && guard < 500);
    checks++;
    assert (rdy_n === 1'b1 && pop_cnt == 126) else begin
      errors++; $error("FAIL ready_return observed=%b/%0d expected=1/126", rdy_n, pop_cnt);
    end
    drain();

    // reset in the middle of a strip
    do_reset();
    gen_frame(0);
    exp_q.delete();
    out_ready = 1'b1;
    feed(0, 40, 100);
    rst_n = 1'b0;
    #2;
    checks++;
    assert (ov_n === 1'b0 && rdy_n === 1'b1) else begin
      errors++; $error("FAIL midreset observed=%b/%b expected=0/1", ov_n, rdy_n);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    gen_frame(0);
    feed(0, 256, 100);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
